// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if
//   Groups the request/response signals of multicycle_alu.
//   Request:  Start, Op[2:0], Src_A, Src_B, C_Flag
//   Response: Busy, Done, Result, Result_Hi, ALUFlags {N,Z,C,V}
//   Modports: master (drives requests), slave (the ALU).
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] Src_A;
    logic [WIDTH-1:0] Src_B;
    logic             C_Flag;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Result_Hi;
    logic [3:0]       ALUFlags;

    modport master (
        output Start, Op, Src_A, Src_B, C_Flag,
        input  Busy, Done, Result, Result_Hi, ALUFlags
    );

    modport slave (
        input  Start, Op, Src_A, Src_B, C_Flag,
        output Busy, Done, Result, Result_Hi, ALUFlags
    );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu
//   ALU with single-cycle ADD/SUB/AND/ORR/ADC/BIC and iterative MUL/DIV
//   (one bit per cycle, WIDTH iterations).
//   Ports:
//     CLK   - clock, rising edge
//     RESET - synchronous active-high reset
//     bus   - multicycle_alu_if.slave (Start/Op/Src_A/Src_B/C_Flag in,
//             Busy/Done/Result/Result_Hi/ALUFlags out, all registered)
//   Configuration:
//     MULTICYCLE_ALU_DIV_EN - when defined, Op 111 is a restoring divider;
//     otherwise Op 111 completes in one cycle with zero results, flags 0101.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    multicycle_alu_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_ADC = 3'b100;
    localparam logic [2:0] OP_BIC = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state_r, state_nx_s;
    logic             busy_r, done_r;
    logic             accept_s, multi_s, last_s;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] result_r, result_hi_r;
    logic [3:0]       flags_r;

    // single-cycle datapath
    logic [WIDTH-1:0] b_eff_s, alu_res_s;
    logic [WIDTH:0]   sum_s;
    logic             cin_s, alu_c_s, alu_v_s;

    // iteration datapath
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] step_hi_s, step_lo_s;
    logic             step_v_s;

`ifdef MULTICYCLE_ALU_DIV_EN
    logic [WIDTH-1:0] b_r;
    logic [WIDTH:0]   div_diff_s;
    logic             q_bit_s;
    assign multi_s = (bus.Op == OP_MUL) || (bus.Op == OP_DIV);
`else
    assign multi_s = (bus.Op == OP_MUL);
`endif

    // Counter runs 0..WIDTH-1 during COMPUTE; the last iteration also retires.
    assign last_s = (cnt_r == CNT_W'(WIDTH - 1));

    // Next-state decode: Start is only honoured outside COMPUTE.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (bus.Start) begin
                    accept_s = 1'b1;
                    if (multi_s) begin
                        state_nx_s = S_COMPUTE;
                    end else begin
                        state_nx_s = S_DONE;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_COMPUTE: begin
                if (last_s) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_COMPUTE;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State register with Busy/Done registered from the next state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == S_COMPUTE);
            done_r  <= (state_nx_s == S_DONE);
        end
    end

    // Single-cycle ops resolve from the live operands on the accepting edge,
    // so the carry-in is consumed there and needs no storage afterwards.
    always_comb begin
        b_eff_s   = bus.Src_B;
        cin_s     = 1'b0;
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (bus.Op)
            OP_SUB: begin
                b_eff_s = ~bus.Src_B;
                cin_s   = 1'b1;
            end
            OP_ADC:  cin_s = bus.C_Flag;
            default: cin_s = 1'b0;
        endcase
        sum_s = {1'b0, bus.Src_A} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
        case (bus.Op)
            OP_ADD, OP_SUB, OP_ADC: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                // Overflow: like-signed addends producing a different sign.
                alu_v_s   = (bus.Src_A[WIDTH-1] == b_eff_s[WIDTH-1]) &&
                            (sum_s[WIDTH-1] != bus.Src_A[WIDTH-1]);
            end
            OP_AND:  alu_res_s = bus.Src_A & bus.Src_B;
            OP_ORR:  alu_res_s = bus.Src_A | bus.Src_B;
            OP_BIC:  alu_res_s = bus.Src_A & ~bus.Src_B;
`ifndef MULTICYCLE_ALU_DIV_EN
            OP_DIV:  alu_v_s   = 1'b1;
`endif
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // One MUL (shift-add, right shifting) or DIV (restoring) iteration.
    // MUL: hi accumulates, lo starts as the multiplier and fills with product.
    // DIV: lo starts as the dividend and fills with quotient, hi is remainder.
    always_comb begin
        mul_sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        step_hi_s = hi_r;
        step_lo_s = lo_r;
        step_v_s  = 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
        div_diff_s = {hi_r, lo_r[WIDTH-1]} - {1'b0, b_r};
        q_bit_s    = ~div_diff_s[WIDTH];
`endif
        if (op_r == OP_MUL) begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
            step_v_s  = (mul_sum_s[WIDTH:1] != {WIDTH{1'b0}});
        end else begin
`ifdef MULTICYCLE_ALU_DIV_EN
            // Divide by zero falls out naturally: all-ones quotient, remainder A.
            step_hi_s = q_bit_s ? div_diff_s[WIDTH-1:0]
                                : {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};
            step_lo_s = {lo_r[WIDTH-2:0], q_bit_s};
            step_v_s  = (b_r == {WIDTH{1'b0}});
`else
            step_hi_s = hi_r;
            step_lo_s = lo_r;
            step_v_s  = 1'b0;
`endif
        end
    end

    // Operand latch, iteration registers and result registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            op_r        <= 3'b000;
            a_r         <= {WIDTH{1'b0}};
`ifdef MULTICYCLE_ALU_DIV_EN
            b_r         <= {WIDTH{1'b0}};
`endif
            hi_r        <= {WIDTH{1'b0}};
            lo_r        <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            flags_r     <= 4'b0000;
        end else if (accept_s) begin
            op_r  <= bus.Op;
            a_r   <= bus.Src_A;
`ifdef MULTICYCLE_ALU_DIV_EN
            b_r   <= bus.Src_B;
`endif
            hi_r  <= {WIDTH{1'b0}};
            lo_r  <= (bus.Op == OP_MUL) ? bus.Src_B : bus.Src_A;
            cnt_r <= {CNT_W{1'b0}};
            if (!multi_s) begin
                result_r    <= alu_res_s;
                result_hi_r <= {WIDTH{1'b0}};
                flags_r     <= {alu_res_s[WIDTH-1], (alu_res_s == {WIDTH{1'b0}}),
                                alu_c_s, alu_v_s};
            end
        end else if (state_r == S_COMPUTE) begin
            hi_r  <= step_hi_s;
            lo_r  <= step_lo_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (last_s) begin
                result_r    <= step_lo_s;
                result_hi_r <= step_hi_s;
                flags_r     <= {step_lo_s[WIDTH-1], (step_lo_s == {WIDTH{1'b0}}),
                                1'b0, step_v_s};
            end
        end
    end

    assign bus.Busy      = busy_r;
    assign bus.Done      = done_r;
    assign bus.Result    = result_r;
    assign bus.Result_Hi = result_hi_r;
    assign bus.ALUFlags  = flags_r;
endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal values 8..64).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port Start, input, 1 bit: request a new operation.
REQ-005 The block SHALL have port Op, input, 3 bits: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 ADC, 101 BIC, 110 MUL, 111 DIV.
REQ-006 The block SHALL have ports Src_A and Src_B, input, WIDTH bits each: the operands.
REQ-007 The block SHALL have port C_Flag, input, 1 bit: carry-in, used by ADC only.
REQ-008 The block SHALL have port Busy, output, 1 bit: a multi-cycle operation is in progress.
REQ-009 The block SHALL have port Done, output, 1 bit: a one-cycle pulse marking Result, Result_Hi and ALUFlags valid.
REQ-010 The block SHALL have port Result, output, WIDTH bits: ALU result, MUL low word, or DIV quotient.
REQ-011 The block SHALL have port Result_Hi, output, WIDTH bits: MUL high word or DIV remainder; 0 for all other ops.
REQ-012 The block SHALL have port ALUFlags, output, 4 bits: {N, Z, C, V}.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, COMPUTE and DONE.
REQ-014 The block SHALL accept Start only in IDLE or DONE, and SHALL latch Op, Src_A, Src_B and C_Flag on the accepting edge.
REQ-015 The block SHALL ignore Start while Busy=1, and SHALL leave the latched operands unchanged.
REQ-016 For ops 000-101, the block SHALL go directly to DONE and assert Done in the cycle after the accepting edge; Busy SHALL stay 0.
REQ-017 For ADD, SUB and ADC, the block SHALL compute a WIDTH+1-bit sum:
- SUB = A + ~B + 1; ADC = A + B + C_Flag.
- C = bit WIDTH of the sum.
- V = signed overflow.
REQ-018 For AND, ORR and BIC, the block SHALL compute A&B, A|B and A&~B, with C=0 and V=0.
REQ-019 For all ops, N SHALL equal Result[WIDTH-1] and Z SHALL be 1 when Result == 0.
REQ-020 For MUL, the block SHALL compute the unsigned product by iterative shift-add, one bit per cycle:
- {Result_Hi, Result} = 2*WIDTH-bit product.
- C=0; V=1 when Result_Hi != 0.
REQ-021 For DIV, the block SHALL compute the unsigned quotient and remainder by restoring division, one bit per cycle:
- Result = quotient, Result_Hi = remainder.
- C=0, V=0.
REQ-022 For DIV with Src_B=0, the block SHALL return Result = all ones and Result_Hi = Src_A, with V=1 and the same latency as a normal DIV.
REQ-023 For MUL and DIV, Busy SHALL be 1 for exactly WIDTH cycles starting the cycle after acceptance; Done SHALL assert in the following cycle (WIDTH+1 cycles after the accepting edge).
REQ-024 Done SHALL be high for exactly one cycle.
REQ-025 Result, Result_Hi and ALUFlags SHALL hold their values until the next Done.
REQ-026 A Start accepted in the DONE cycle SHALL begin a new operation back-to-back, with no idle cycle.
REQ-027 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL not wrap during an operation.

Reset
REQ-028 When RESET=1 at a rising edge, the state SHALL become IDLE and Busy, Done, Result, Result_Hi and ALUFlags SHALL all become 0.
REQ-029 RESET SHALL take priority over a simultaneous Start.
REQ-030 RESET during COMPUTE SHALL abort the operation; no Done SHALL be produced for it.

Configuration
REQ-031 The divider SHALL be compiled in only when macro MULTICYCLE_ALU_DIV_EN is defined.
REQ-032 With MULTICYCLE_ALU_DIV_EN defined, Op 111 SHALL behave as specified in REQ-021 to REQ-023.
REQ-033 Without MULTICYCLE_ALU_DIV_EN, Op 111 SHALL complete as a single-cycle op with Result=0, Result_Hi=0 and ALUFlags=0101, and no divider logic SHALL be synthesised.

Verification (WIDTH=32)
REQ-034 ADD with 0x7FFFFFFF + 0x00000001 SHALL give Done after 1 cycle, Result 0x80000000, ALUFlags 1001.
REQ-035 SUB with 5 - 5 SHALL give Result 0, Result_Hi 0, ALUFlags 0110; ADC with 0xFFFFFFFF + 0 + C_Flag=1 SHALL give Result 0, ALUFlags 0110.
REQ-036 MUL with 0x00010000 * 0x00010000 SHALL give Busy for 32 cycles, Done at cycle 33, Result 0, Result_Hi 1, ALUFlags 0101.
REQ-037 DIV with 100 / 7 SHALL give Done at cycle 33, Result 14, Result_Hi 2, ALUFlags 0000; DIV with 9 / 0 SHALL give Result 0xFFFFFFFF, Result_Hi 9, ALUFlags 1001.
REQ-038 MUL started, then RESET at cycle 10 SHALL give Busy=0 and all outputs 0 next cycle, and no Done; a second Start held during Busy SHALL be ignored.
REQ-039 Back-to-back: a Start with AND 0xF0F0F0F0 & 0xFF00FF00, asserted in the Done cycle of a MUL, SHALL give Done one cycle later with Result 0xF000F000 and ALUFlags 1000.
